// File: rtl/buffer_access_sequencer.sv
// Sequences one byte/halfword/word host access into byte-wide buffer push/pop
// cycles, and turns flush requests into a single one-cycle clear command.
module buffer_access_sequencer #(
  parameter int unsigned BUFFER_DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        hwrite_req,
  input  logic [1:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic [7:0]  rx_data,
  input  logic [6:0]  buffer_occupancy,
  input  logic        flush_req,
  output logic        get_rx_data,
  output logic        store_tx_data,
  output logic [7:0]  tx_data,
  output logic [31:0] hrdata_buf,
  output logic        busy,
  output logic        done,
  output logic        access_error,
  output logic        clear
);

  localparam logic [7:0] DepthW = 8'(BUFFER_DEPTH);

  typedef enum logic [2:0] {StIdle, StXfer, StDone, StErr, StFlush} state_e;

  state_e     state;
  logic [2:0] nbytes;
  logic [1:0] idx;
  logic       write;
  logic       flush_pend;

  logic [3:0] req_bytes;
  logic [7:0] occ_ext;
  logic [7:0] n_ext;
  logic       req_bad;
  logic       last_byte;

  always_comb begin
    req_bytes = 4'd1 << hsize;
    occ_ext   = {1'b0, buffer_occupancy};
    n_ext     = {4'b0000, req_bytes};
    // Reads need N bytes present; writes need N bytes of free space.
    req_bad   = (hsize == 2'd3) ||
                (!hwrite_req && (occ_ext < n_ext)) ||
                (hwrite_req && ((occ_ext + n_ext) > DepthW));
    last_byte = ({1'b0, idx} == (nbytes - 3'd1));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= StIdle;
      nbytes     <= 3'd0;
      idx        <= 2'd0;
      write      <= 1'b0;
      flush_pend <= 1'b0;
      hrdata_buf <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            nbytes <= req_bytes[2:0];
            write  <= hwrite_req;
            idx    <= 2'd0;
            if (flush_req) flush_pend <= 1'b1;
            if (req_bad) begin
              state <= StErr;
            end else begin
              state <= StXfer;
              if (!hwrite_req) hrdata_buf <= 32'h0;
            end
          end else if (flush_req || flush_pend) begin
            state <= StFlush;
          end
        end
        StXfer: begin
          if (flush_req) flush_pend <= 1'b1;
          if (!write) hrdata_buf[{idx, 3'b000} +: 8] <= rx_data;
          if (last_byte) begin
            state <= StDone;
            idx   <= 2'd0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        StDone: begin
          state <= (flush_pend || flush_req) ? StFlush : StIdle;
        end
        StErr: begin
          // A pending flush is picked up from IDLE on the next cycle.
          if (flush_req) flush_pend <= 1'b1;
          state <= StIdle;
        end
        StFlush: begin
          flush_pend <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy          = (state != StIdle);
  assign done          = (state == StDone);
  assign access_error  = (state == StErr);
  assign clear         = (state == StFlush);
  assign store_tx_data = (state == StXfer) && write;
  assign get_rx_data   = (state == StXfer) && !write;
  assign tx_data       = store_tx_data ? hwdata[{idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_buffer_access_sequencer.sv
// Scoreboard bench: stimulus pushes expected strobe events, a negedge monitor
// pops and compares them whenever the sequencer raises a strobe.
module tb_buffer_access_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        hwrite_req = 1'b0;
  logic [1:0]  hsize = 2'd0;
  logic [31:0] hwdata = 32'h0;
  logic [7:0]  rx_data;
  logic [6:0]  buffer_occupancy = 7'd0;
  logic        flush_req = 1'b0;
  logic        get_rx_data, store_tx_data, busy, done, access_error, clear;
  logic [7:0]  tx_data;
  logic [31:0] hrdata_buf;

  buffer_access_sequencer #(.BUFFER_DEPTH(64)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .hwrite_req       (hwrite_req),
    .hsize            (hsize),
    .hwdata           (hwdata),
    .rx_data          (rx_data),
    .buffer_occupancy (buffer_occupancy),
    .flush_req        (flush_req),
    .get_rx_data      (get_rx_data),
    .store_tx_data    (store_tx_data),
    .tx_data          (tx_data),
    .hrdata_buf       (hrdata_buf),
    .busy             (busy),
    .done             (done),
    .access_error     (access_error),
    .clear            (clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: head byte presented combinationally, popped on get.
  logic [7:0] rx_mem [256];
  logic [7:0] rx_ptr = 8'd0;
  assign rx_data = rx_mem[rx_ptr];
  always @(posedge clk) if (get_rx_data) rx_ptr <= rx_ptr + 8'd1;

  localparam int KGet = 0, KStore = 1, KDone = 2, KErr = 3, KClr = 4;
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data, input int c);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (n_rst) begin
      int nact;
      ev_t e;
      int akind;
      logic [31:0] adata;
      nact = int'(get_rx_data) + int'(store_tx_data) + int'(done) + int'(access_error) +
             int'(clear);
      check("strobe_exclusive", 64'(nact > 1), 64'd0);
      if (!store_tx_data) check("tx_data_idle_zero", 64'(tx_data), 64'd0);
      if (nact >= 1) begin
        if (get_rx_data)        begin akind = KGet;   adata = {24'h0, tx_data}; end
        else if (store_tx_data) begin akind = KStore; adata = {24'h0, tx_data}; end
        else if (done)          begin akind = KDone;  adata = hrdata_buf; end
        else if (access_error)  begin akind = KErr;   adata = hrdata_buf; end
        else                    begin akind = KClr;   adata = hrdata_buf; end
        nchk++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, expected none",
                   akind, adata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (akind != e.kind || adata !== e.data || cyc != e.cyc) begin
            nfail++;
            $display("FAIL scoreboard: got kind %0d data %h cycle %0d, expected kind %0d data %h cycle %0d",
                     akind, adata, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic load_rx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
    rx_mem[rx_ptr]         = b0;
    rx_mem[rx_ptr + 8'd1]  = b1;
    rx_mem[rx_ptr + 8'd2]  = b2;
    rx_mem[rx_ptr + 8'd3]  = b3;
  endtask

  task automatic access(input string name, input bit wr, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [6:0] occ, input bit err,
                        input logic [31:0] exp_hr, input bit fl, input int mid_fl,
                        input bit restart);
    int n, t0, bcnt, exp_busy;
    n = 1 << sz;
    @(negedge clk);
    t0 = cyc;
    if (err) begin
      push(KErr, exp_hr, t0 + 1);
      if (mid_fl > 0) push(KClr, exp_hr, t0 + 3);
      exp_busy = 1;
    end else begin
      for (int j = 0; j < n; j++)
        push(wr ? KStore : KGet, wr ? ((wd >> (8 * j)) & 32'hff) : 32'h0, t0 + 1 + j);
      push(KDone, exp_hr, t0 + 1 + n);
      if (fl || mid_fl > 0) push(KClr, exp_hr, t0 + 2 + n);
      exp_busy = n + 1 + ((fl || mid_fl > 0) ? 1 : 0);
    end
    start = 1'b1; hwrite_req = wr; hsize = sz; hwdata = wd;
    buffer_occupancy = occ; flush_req = fl;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start      = restart && (k == 1);
      hwrite_req = (restart && k == 1) ? !wr : wr;
      flush_req  = (k == mid_fl);
      if (!busy) break;
      bcnt++;
    end
    start = 1'b0; flush_req = 1'b0; hwrite_req = wr;
    check({"busy_cycles_", name}, 64'(bcnt), 64'(exp_busy));
  endtask

  initial begin
    int t0;
    #12;
    check("reset_outputs",
          {get_rx_data, store_tx_data, tx_data, hrdata_buf, busy, done, access_error, clear},
          64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    access("word_write",  1'b1, 2'd2, 32'hA1B2C3D4, 7'd0,  1'b0, 32'h0, 1'b0, 0, 1'b0);
    load_rx(8'h11, 8'h22, 8'h00, 8'h00);
    access("half_read",   1'b0, 2'd1, 32'h0,       7'd5,  1'b0, 32'h00002211, 1'b0, 0, 1'b0);
    access("byte_write_full_edge", 1'b1, 2'd0, 32'h0000005A, 7'd63, 1'b0, 32'h00002211,
           1'b0, 0, 1'b1);
    access("err_word_read",  1'b0, 2'd2, 32'h0, 7'd3,  1'b1, 32'h00002211, 1'b0, 0, 1'b0);
    access("err_word_write", 1'b1, 2'd2, 32'h0, 7'd61, 1'b1, 32'h00002211, 1'b0, 0, 1'b0);
    access("err_hsize3",     1'b1, 2'd3, 32'h0, 7'd0,  1'b1, 32'h00002211, 1'b0, 0, 1'b0);
    access("err_byte_read",  1'b0, 2'd0, 32'h0, 7'd0,  1'b1, 32'h00002211, 1'b0, 0, 1'b0);
    access("word_write_60",  1'b1, 2'd2, 32'h01020304, 7'd60, 1'b0, 32'h00002211,
           1'b0, 0, 1'b0);
    load_rx(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    access("word_read_4",    1'b0, 2'd2, 32'h0, 7'd4, 1'b0, 32'hEFBEADDE, 1'b0, 0, 1'b0);
    load_rx(8'h01, 8'h02, 8'h03, 8'h04);
    access("flush_collision", 1'b0, 2'd2, 32'h0, 7'd8, 1'b0, 32'h04030201, 1'b1, 2, 1'b0);
    access("err_with_flush", 1'b0, 2'd2, 32'h0, 7'd0, 1'b1, 32'h04030201, 1'b0, 1, 1'b0);
    repeat (3) @(negedge clk);

    // Idle flush alone
    @(negedge clk);
    push(KClr, 32'h04030201, cyc + 1);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check("flush_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("flush_back_idle", 64'(busy), 64'd0);

    // Reset in the middle of a word read
    load_rx(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    @(negedge clk);
    t0 = cyc;
    push(KGet, 32'h0, t0 + 1);
    push(KGet, 32'h0, t0 + 2);
    start = 1'b1; hwrite_req = 1'b0; hsize = 2'd2; buffer_occupancy = 7'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {get_rx_data, store_tx_data, tx_data, hrdata_buf, busy, done, access_error, clear},
          64'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_hrdata", 64'(hrdata_buf), 64'd0);
    repeat (6) @(negedge clk);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
